qam_demapper_param: RTL

Parametrised hard-decision QAM demapper (QPSK/16QAM/64QAM) with calibrated DC-offset removal and a gapless serial bit output.
- Accepts one signed I/Q sample per handshake, subtracts a calibrated offset and slices each axis to a Gray-coded level index.
- Shifts the 2k-bit symbol out MSB first, one bit per clock.
- Sits between the I/Q sample source and the serial bit sink.
- Replaces the fixed 16QAM, two-clock demapper with a single-clock, mode-selectable design.

---
 rtl/qam_demapper_pkg.sv | 34 +++
 rtl/qam_axis_slicer.sv | 47 ++++
 rtl/qam_demapper_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/qam_demapper_pkg.sv
// Shared encodings and helpers for the parametrised QAM demapper.
package qam_demapper_pkg;

  typedef enum logic [1:0] {
    MODE_QPSK  = 2'b00,
    MODE_16QAM = 2'b01,
    MODE_64QAM = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CAL  = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  // Widest symbol word: two axes of 3 bits (64QAM).
  localparam int SYM_BITS_MAX = 6;

  // Bits per axis k; the reserved mode falls back to QPSK.
  function automatic logic [1:0] bits_per_axis(input logic [1:0] mode);
    case (mode_t'(mode))
      MODE_16QAM: return 2'd2;
      MODE_64QAM: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  // Binary level index to Gray code.
  function automatic logic [2:0] gray(input logic [2:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/qam_axis_slicer.sv
// One-axis hard slicer: offset removal, saturation, level decision, Gray encode.
module qam_axis_slicer
  import qam_demapper_pkg::*;
#(
  parameter int W         = 8,
  parameter int UNIT_LOG2 = 4
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] off,
  input  logic        [1:0]   k,
  output logic        [2:0]   g
);

  logic signed [W:0]   diff;
  logic signed [W-1:0] cs;
  logic signed [W-1:0] lvl;
  logic signed [W+1:0] half;
  logic signed [W+1:0] top;
  logic signed [W+1:0] idx_s;
  logic        [2:0]   idx;

  // Subtract offset at W+1 bits, saturate, floor-divide by 2U and clamp to M levels.
  always_comb begin
    diff = (W+1)'(x) - (W+1)'(off);
    if (diff[W] != diff[W-1]) begin
      cs = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      cs = diff[W-1:0];
    end
    lvl = cs >>> (UNIT_LOG2 + 1);
    case (k)
      2'd2: begin half = (W+2)'(2); top = (W+2)'(3); end
      2'd3: begin half = (W+2)'(4); top = (W+2)'(7); end
      default: begin half = (W+2)'(1); top = (W+2)'(1); end
    endcase
    idx_s = (W+2)'(lvl) + half;
    if (idx_s[W+1]) begin
      idx = 3'd0;
    end else if (idx_s > top) begin
      idx = top[2:0];
    end else begin
      idx = idx_s[2:0];
    end
    g = gray(idx);
  end

endmodule

// File: rtl/qam_demapper_param.sv
// Mode-selectable QAM demapper with DC-offset calibration and gapless serial output.
module qam_demapper_param
  import qam_demapper_pkg::*;
#(
  parameter int W         = 8,
  parameter int UNIT_LOG2 = 4,
  parameter int CAL_LOG2  = 4
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                en,
  input  logic                cal,
  input  logic [1:0]          mode,
  input  logic                in_valid,
  input  logic signed [W-1:0] I_in,
  input  logic signed [W-1:0] Q_in,
  output logic                in_ready,
  output logic                data_out,
  output logic                data_valid,
  output logic                sym_start,
  output logic                cal_done
);

  localparam int AW = W + CAL_LOG2;
  localparam logic [CAL_LOG2:0] CAL_LAST = (CAL_LOG2+1)'(2**CAL_LOG2 - 1);

  state_t state, state_nx;

  logic signed [AW-1:0]     acc_i, acc_q;
  logic signed [AW-1:0]     sum_i, sum_q;
  logic signed [AW-1:0]     avg_i, avg_q;
  logic        [CAL_LOG2:0] cal_cnt;
  logic signed [W-1:0]      off_i, off_q;

  logic [SYM_BITS_MAX-1:0] sh, word;
  logic [2:0]              cnt;
  logic [1:0]              k_in;
  logic [2:0]              g_i, g_q;
  logic                    accept, cal_last;

  assign accept     = in_valid && in_ready;
  assign cal_last   = (cal_cnt == CAL_LAST);
  assign k_in       = bits_per_axis(mode);
  assign data_out   = sh[SYM_BITS_MAX-1];
  assign data_valid = (cnt != 3'd0);
  assign sum_i      = acc_i + AW'(I_in);
  assign sum_q      = acc_q + AW'(Q_in);
  assign avg_i      = sum_i >>> CAL_LOG2;
  assign avg_q      = sum_q >>> CAL_LOG2;

  qam_axis_slicer #(.W(W), .UNIT_LOG2(UNIT_LOG2)) u_slice_i (
    .x(I_in), .off(off_i), .k(k_in), .g(g_i)
  );

  qam_axis_slicer #(.W(W), .UNIT_LOG2(UNIT_LOG2)) u_slice_q (
    .x(Q_in), .off(off_q), .k(k_in), .g(g_q)
  );

  // Left-align the {g_I, g_Q} word so the shifter always emits from its MSB.
  always_comb begin
    word = '0;
    case (k_in)
      2'd3:    word = {g_i, g_q};
      2'd2:    word = {g_i[1:0], g_q[1:0], 2'b00};
      default: word = {g_i[0], g_q[0], 4'b0000};
    endcase
  end

  // State register.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and ready; RUN accepts while the shifter is empty or on its last bit.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cal)     state_nx = ST_CAL;
        else if (en) state_nx = ST_RUN;
      end
      ST_CAL: begin
        in_ready = 1'b1;
        if (in_valid && cal_last) state_nx = ST_IDLE;
      end
      ST_RUN: begin
        in_ready = en && (cnt <= 3'd1);
        if (!en && cnt == 3'd0) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Calibration accumulators; the last sample's sum is averaged directly into the offsets.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      acc_i    <= '0;
      acc_q    <= '0;
      cal_cnt  <= '0;
      off_i    <= '0;
      off_q    <= '0;
      cal_done <= 1'b0;
    end else begin
      cal_done <= 1'b0;
      if (state == ST_CAL && accept) begin
        if (cal_last) begin
          off_i    <= avg_i[W-1:0];
          off_q    <= avg_q[W-1:0];
          acc_i    <= '0;
          acc_q    <= '0;
          cal_cnt  <= '0;
          cal_done <= 1'b1;
        end else begin
          acc_i   <= sum_i;
          acc_q   <= sum_q;
          cal_cnt <= cal_cnt + 1'b1;
        end
      end
    end
  end

  // Output shifter: load on acceptance in RUN, otherwise shift while bits remain.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      cnt       <= '0;
      sym_start <= 1'b0;
    end else if (state == ST_RUN && accept) begin
      sh        <= word;
      cnt       <= {k_in, 1'b0};
      sym_start <= 1'b1;
    end else if (cnt != 3'd0) begin
      sh        <= sh << 1;
      cnt       <= cnt - 3'd1;
      sym_start <= 1'b0;
    end
  end

endmodule
